// File: rtl/pixel_pkg.sv
// pixel_pkg: screen geometry, colors, FSM states and (x,y) to address mapping
package pixel_pkg;
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int ADDR_W = 15;
   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;
   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_RD_ISSUE, S_RD_WAIT} state_t;
   function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] x, input logic [6:0] y);
      return ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
   endfunction
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO with combinational head output
module pixel_fifo #(
   parameter int W = 18,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wp <= '0;
         rp <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
   always_ff @(posedge clk)
      if (push) mem[wp] <= din;
   assign dout = mem[rp];
   assign full = cnt == (AW+1)'(DEPTH);
   assign empty = cnt == '0;
endmodule

// File: rtl/pixel_write_receiver.sv
// pixel_write_receiver: buffers draw-stream pixels into video RAM and serves ordered read-backs
module pixel_write_receiver
   import pixel_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        x_in,
   input  logic [6:0]        y_in,
   input  logic [2:0]        color_in,
   input  logic              writeEn,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [2:0]        mem_wdata,
   output logic              mem_we,
   input  logic              mem_ready,
   input  logic [2:0]        mem_rdata,
   input  logic              rd_req,
   input  logic [7:0]        rd_x,
   input  logic [6:0]        rd_y,
   output logic              rd_busy,
   output logic              rd_valid,
   output logic [2:0]        rd_color,
   output logic              oob_flag,
   output logic [7:0]        drop_count
);
   state_t state, nxt;
   logic full, empty, push, pop, in_range, rd_in_range, rd_take;
   logic [ADDR_W+2:0] head;
   logic [ADDR_W-1:0] rd_addr;
   assign in_range = (x_in < 8'(SCREEN_W)) && (y_in < 7'(SCREEN_H));
   assign rd_in_range = (rd_x < 8'(SCREEN_W)) && (rd_y < 7'(SCREEN_H));
   assign pop = (state == S_DRAIN) && mem_ready && !empty;
   assign push = writeEn && in_range && (!full || pop);
   assign rd_take = rd_req && !rd_busy;
   pixel_fifo #(.W(ADDR_W+3), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(push), .pop(pop),
      .din({xy_to_addr(x_in, y_in), color_in}), .dout(head),
      .full(full), .empty(empty)
   );
   // Any queued or incoming write takes priority over a read, keeping write-before-read order
   always_comb begin
      nxt = state;
      mem_we = 1'b0;
      mem_addr = '0;
      mem_wdata = BLACK;
      case (state)
         S_IDLE:
            if (!empty || push) nxt = S_DRAIN;
            else if (rd_busy || (rd_take && rd_in_range)) nxt = S_RD_ISSUE;
         S_DRAIN: begin
            mem_we = !empty;
            mem_addr = head[ADDR_W+2:3];
            mem_wdata = head[2:0];
            if (empty && !push) nxt = S_IDLE;
         end
         S_RD_ISSUE: begin
            mem_addr = rd_addr;
            if (mem_ready) nxt = S_RD_WAIT;
         end
         default: begin
            mem_addr = rd_addr;
            nxt = S_IDLE;
         end
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= S_IDLE;
         oob_flag <= 1'b0;
         drop_count <= '0;
         rd_busy <= 1'b0;
         rd_valid <= 1'b0;
         rd_color <= BLACK;
         rd_addr <= '0;
      end else begin
         state <= nxt;
         if (writeEn && !in_range) oob_flag <= 1'b1;
         if (writeEn && in_range && !push && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
         rd_valid <= (state == S_RD_WAIT) || (rd_take && !rd_in_range);
         if (state == S_RD_WAIT) rd_color <= mem_rdata;
         else if (rd_take && !rd_in_range) rd_color <= BLACK;
         if (state == S_RD_WAIT) rd_busy <= 1'b0;
         else if (rd_take && rd_in_range) begin
            rd_busy <= 1'b1;
            rd_addr <= xy_to_addr(rd_x, rd_y);
         end
      end
endmodule

// File: tb/tb_pixel_write_receiver.sv
// tb_pixel_write_receiver: directed checks against a behavioural RAM model
module tb_pixel_write_receiver;
   import pixel_pkg::*;
   logic clk = 0, reset = 1;
   logic [7:0] x_in = 0, rd_x = 0;
   logic [6:0] y_in = 0, rd_y = 0;
   logic [2:0] color_in = 0, mem_wdata, mem_rdata = 0, rd_color;
   logic writeEn = 0, mem_we, mem_ready = 0, rd_req = 0, rd_busy, rd_valid, oob_flag;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0] drop_count;
   int passed = 0, total = 0, lat, nv;
   logic [2:0] ram [19200];
   int wa[$], wd[$];

   pixel_write_receiver dut (
      .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .color_in(color_in), .writeEn(writeEn),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_busy(rd_busy),
      .rd_valid(rd_valid), .rd_color(rd_color), .oob_flag(oob_flag), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (mem_ready) begin
         if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wa.push_back(int'(mem_addr));
            wd.push_back(int'(mem_wdata));
         end
         mem_rdata <= ram[mem_addr];
      end

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic do_reset();
      reset = 1;
      writeEn = 0;
      rd_req = 0;
      mem_ready = 0;
      repeat (2) @(negedge clk);
      reset = 0;
      wa.delete();
      wd.delete();
   endtask

   task automatic wr(input int x, input int y, input int c);
      @(negedge clk);
      x_in = 8'(x);
      y_in = 7'(y);
      color_in = 3'(c);
      writeEn = 1;
   endtask

   task automatic rd(input int x, input int y);
      @(negedge clk);
      writeEn = 0;
      rd_x = 8'(x);
      rd_y = 7'(y);
      rd_req = 1;
   endtask

   task automatic idle();
      @(negedge clk);
      writeEn = 0;
      rd_req = 0;
   endtask

   task automatic wait_valid(output int l);
      l = 99;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         rd_req = 0;
         if (rd_valid) begin
            l = i;
            return;
         end
      end
   endtask

   task automatic check_reset_outputs(input string p);
      check({p, "_mem_we"}, int'(mem_we), 0);
      check({p, "_mem_addr"}, int'(mem_addr), 0);
      check({p, "_mem_wdata"}, int'(mem_wdata), 0);
      check({p, "_rd_busy"}, int'(rd_busy), 0);
      check({p, "_rd_valid"}, int'(rd_valid), 0);
      check({p, "_oob_flag"}, int'(oob_flag), 0);
      check({p, "_drop_count"}, int'(drop_count), 0);
   endtask

   initial begin
      for (int i = 0; i < 19200; i++) ram[i] = 0;
      #1;
      check_reset_outputs("rst");
      check("rst_rd_color", int'(rd_color), 0);
      do_reset();

      mem_ready = 1;
      wr(3, 3, 5);
      idle();
      check("w1_we", int'(mem_we), 1);
      check("w1_addr", int'(mem_addr), 483);
      check("w1_wdata", int'(mem_wdata), 5);
      @(negedge clk);
      check("w1_fifo_empty", int'(dut.u_fifo.empty), 1);
      check("w1_count", wa.size(), 1);

      do_reset();
      for (int i = 0; i < 12; i++) wr(i, 1, (i % 7) + 1);
      idle();
      check("q12_drops", int'(drop_count), 4);
      check("q12_no_write", wa.size(), 0);
      mem_ready = 1;
      repeat (12) @(negedge clk);
      check("q12_writes", wa.size(), 8);
      for (int i = 0; i < 8 && i < wa.size(); i++) begin
         check($sformatf("q12_addr%0d", i), wa[i], 160 + i);
         check($sformatf("q12_data%0d", i), wd[i], (i % 7) + 1);
      end

      do_reset();
      mem_ready = 1;
      wr(160, 0, 7);
      wr(0, 120, 7);
      idle();
      repeat (5) @(negedge clk);
      check("oob_writes", wa.size(), 0);
      check("oob_flag", int'(oob_flag), 1);
      check("oob_drops", int'(drop_count), 0);

      do_reset();
      mem_ready = 1;
      wr(10, 5, 7);
      rd(10, 5);
      wait_valid(lat);
      check("raw_valid_seen", int'(lat < 30), 1);
      check("raw_write_first", wa.size(), 1);
      check("raw_color", int'(rd_color), 7);
      check("raw_busy", int'(rd_busy), 0);
      @(negedge clk);
      check("raw_valid_pulse", int'(rd_valid), 0);
      repeat (3) @(negedge clk);
      rd(10, 5);
      wait_valid(lat);
      check("rd_latency", lat, 3);
      check("rd_color_again", int'(rd_color), 7);
      rd(11, 5);
      wait_valid(lat);
      check("rd_black_color", int'(rd_color), 0);
      rd(10, 5);
      wait_valid(lat);
      rd(200, 0);
      wait_valid(lat);
      check("rd_oob_latency", lat, 1);
      check("rd_oob_color", int'(rd_color), 0);

      do_reset();
      for (int i = 0; i < 5; i++) wr(i, 2, 6);
      rd(1, 2);
      idle();
      check("mid_busy", int'(rd_busy), 1);
      mem_ready = 1;
      @(negedge clk);
      check("mid_draining", int'(mem_we), 1);
      #2 reset = 1;
      #1;
      check_reset_outputs("mid");
      check("mid_rd_color", int'(rd_color), 0);
      repeat (2) @(negedge clk);
      reset = 0;
      wa.delete();
      wd.delete();
      nv = 0;
      repeat (10) begin
         @(negedge clk);
         if (rd_valid) nv++;
      end
      check("mid_no_writes", wa.size(), 0);
      check("mid_no_valid", nv, 0);

      do_reset();
      for (int i = 0; i < 8; i++) wr(i, 0, 2);
      @(negedge clk);
      mem_ready = 1;
      x_in = 50;
      y_in = 50;
      color_in = 3;
      writeEn = 1;
      idle();
      check("pp_full_no_drop", int'(drop_count), 0);
      repeat (12) @(negedge clk);
      check("pp_writes", wa.size(), 9);
      if (wa.size() == 9) begin
         check("pp_last_addr", wa[8], 8050);
         check("pp_last_data", wd[8], 3);
      end
      mem_ready = 0;
      for (int i = 0; i < 308; i++) wr(i % 160, 7, 1);
      idle();
      check("sat_drops", int'(drop_count), 255);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
